// File: rtl/alu_muldiv_seq.sv
// Sequential MUL (shift-add) / unsigned DIV (restoring) iterating the shared ALU; ALU_MULDIV_SEQ_EARLY_EXIT_EN lets MUL stop once the multiplier is exhausted.
// Latency accept->resp_valid W+1 cycles (early-exit MUL: iterations+1), DIV by zero 1 cycle.
// Backpressure: result held in DONE until resp_ready; req_ready only in IDLE, one op in flight.
module alu_muldiv_seq #(
  parameter int W     = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [W-1:0]     resp_data,
  output logic [W-1:0]     resp_rem,
  output logic             resp_zero,
  output logic             resp_div0,
  output logic             alu_own,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_mode,
  output logic             alu_carry,
  input  logic [W-1:0]     alu_out,
  input  logic [4:0]       alu_flags
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic             op;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     mcand;   // multiplicand, or divisor for DIV
  logic [W-1:0]     mplr;
  logic [W-1:0]     rem_r;
  logic [W-1:0]     quo;

  logic [W-1:0]     mcand_nxt, mplr_nxt, rem_nxt, quo_nxt;
  logic             take, last;

  assign req_ready = (state == S_IDLE);
  assign alu_carry = 1'b0;

  // alu_a already holds the shifted partial remainder rs; rem_r[W-1] is the bit shifted out of it.
  always_comb begin
    mcand_nxt = mcand << 1;
    mplr_nxt  = mplr >> 1;
    take      = rem_r[W-1] | ~alu_flags[1];
    rem_nxt   = take ? alu_out : alu_a;
    quo_nxt   = {quo[W-2:0], take};
    last      = (cnt == CNT_W'(W-1));
`ifdef ALU_MULDIV_SEQ_EARLY_EXIT_EN
    if (!op && (mplr_nxt == '0)) last = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      mplr       <= '0;
      rem_r      <= '0;
      quo        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rem   <= '0;
      resp_zero  <= 1'b0;
      resp_div0  <= 1'b0;
      alu_own    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op  <= req_op;
            cnt <= '0;
            if (req_op && (req_b == '0)) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_data  <= '1;
              resp_rem   <= req_a;
              resp_zero  <= 1'b0;
              resp_div0  <= 1'b1;
            end else begin
              state   <= S_RUN;
              alu_own <= 1'b1;
              mcand   <= req_op ? req_b : req_a;
              mplr    <= req_b;
              rem_r   <= '0;
              quo     <= req_a;
              if (req_op) begin
                alu_a    <= {{(W-1){1'b0}}, req_a[W-1]};
                alu_b    <= req_b;
                alu_mode <= 4'b0001;
              end else begin
                alu_a    <= '0;
                alu_b    <= req_b[0] ? req_a : '0;
                alu_mode <= 4'b0000;
              end
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (!op) begin
            alu_a <= alu_out;
            mcand <= mcand_nxt;
            mplr  <= mplr_nxt;
            alu_b <= mplr_nxt[0] ? mcand_nxt : '0;
          end else begin
            rem_r <= rem_nxt;
            quo   <= quo_nxt;
            alu_a <= {rem_nxt[W-2:0], quo[W-2]};
          end
          if (last) begin
            state      <= S_DONE;
            alu_own    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mode   <= 4'b0000;
            resp_valid <= 1'b1;
            resp_data  <= op ? quo_nxt : alu_out;
            resp_rem   <= op ? rem_nxt : '0;
            resp_zero  <= ((op ? quo_nxt : alu_out) == '0);
            resp_div0  <= 1'b0;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{alu_flags[4:2], alu_flags[0], quo[W-1]};

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed + random bench for alu_muldiv_seq with a behavioural ALU and arithmetic reference model.
module tb_alu_muldiv_seq;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_op;
  logic [W-1:0]  req_a, req_b;
  logic          resp_valid, resp_ready;
  logic [W-1:0]  resp_data, resp_rem;
  logic          resp_zero, resp_div0;
  logic          alu_own, alu_carry;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [3:0]    alu_mode;
  logic [4:0]    alu_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.W(W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rem(resp_rem),
    .resp_zero(resp_zero), .resp_div0(resp_div0),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_carry(alu_carry), .alu_out(alu_out), .alu_flags(alu_flags)
  );

  // Shared ALU: ADD or SUB, flags bit1 = carry (ADD) / borrow (SUB), bit0 = zero.
  logic [W:0] alu_wide;
  always_comb begin
    if (alu_mode == 4'b0001) alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
    else                     alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_carry};
    alu_out   = alu_wide[W-1:0];
    alu_flags = {3'b000, alu_wide[W], (alu_wide[W-1:0] == '0)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mul_iters(input logic [W-1:0] b);
`ifdef ALU_MULDIV_SEQ_EARLY_EXIT_EN
    int n = 0;
    int t = int'(b);
    do begin n++; t = t >> 1; end while (t != 0);
    return n;
`else
    return W;
`endif
  endfunction

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] ed, er;
    logic         ediv0;
    int           exp_lat, lat, own_cnt, w;
    bit           mode_bad, ready_bad;
    if (op == 1'b0) begin
      ed = W'(int'(a) * int'(b));
      er = '0; ediv0 = 1'b0; exp_lat = mul_iters(b) + 1;
    end else if (b == '0) begin
      ed = '1; er = a; ediv0 = 1'b1; exp_lat = 1;
    end else begin
      ed = a / b; er = a % b; ediv0 = 1'b0; exp_lat = W + 1;
    end
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk("req_ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    lat = 0; own_cnt = 0; mode_bad = 1'b0; ready_bad = 1'b0;
    do begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat++;
      if (alu_own) begin
        own_cnt++;
        if (alu_mode !== {3'b000, op} || alu_carry !== 1'b0) mode_bad = 1'b1;
      end
      if (req_ready) ready_bad = 1'b1;
    end while (!resp_valid && lat < 40);
    chk($sformatf("latency op=%0d a=%0h b=%0h", op, a, b), 32'(lat), 32'(exp_lat));
    chk("resp_data", 32'(resp_data), 32'(ed));
    chk("resp_rem", 32'(resp_rem), 32'(er));
    chk("resp_zero", 32'(resp_zero), 32'(ed == '0));
    chk("resp_div0", 32'(resp_div0), 32'(ediv0));
    chk("alu_own_cycles", 32'(own_cnt), ediv0 ? 32'd0 : 32'(exp_lat - 1));
    chk("alu_mode_during_run", 32'(mode_bad), 32'd0);
    chk("req_ready_while_busy", 32'(ready_bad), 32'd0);
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    if (hold > 0) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", {resp_data, resp_rem}, {ed, er});
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_hs_valid", 32'(resp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit seen_resp;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_alu_own", 32'(alu_own), 32'd0);
    chk("rst_outputs", {resp_data, resp_rem}, 32'd0);
    chk("rst_alu_ops", {alu_a, alu_b}, 32'd0);
    chk("rst_misc", {26'd0, alu_mode, resp_zero, resp_div0}, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    run_op(1'b0, 16'd7, 16'd6, 0);
    run_op(1'b0, 16'h1234, 16'h0010, 0);
    run_op(1'b1, 16'd100, 16'd7, 0);
    run_op(1'b1, 16'hFFFF, 16'h8001, 0);
    run_op(1'b1, 16'd5, 16'd0, 0);
    run_op(1'b0, 16'd3, 16'd2, 0);
    run_op(1'b0, 16'h0100, 16'h0100, 0);
    run_op(1'b0, 16'hABCD, 16'd0, 0);
    run_op(1'b1, 16'd3, 16'd9, 5);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 5);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      logic         rop;
      ra  = W'($urandom);
      rop = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      run_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    // Reset while a MUL is in RUN: must abort and never respond.
    req_valid = 1'b1; req_op = 1'b0; req_a = 16'd9; req_b = 16'hFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_run_own", 32'(alu_own), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_alu_own", 32'(alu_own), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    seen_resp = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (resp_valid || alu_own) seen_resp = 1'b1;
    end
    resp_ready = 1'b0;
    chk("abort_no_response", 32'(seen_resp), 32'd0);

    run_op(1'b1, 16'd1000, 16'd10, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
